// File: rtl/strobe_gen_pkg.sv
// Package: strobe_gen_pkg
// Purpose : Shared constants and helpers for the strobe generator.
//           calc_cycles() turns a clock frequency and a strobe period into
//           the number of system clocks per strobe (N), using 64-bit math
//           so large CLOCK_HZ * PERIOD_US products cannot overflow.
// Contents: US_PER_S    microseconds per second
//           calc_cycles (clock_hz, period_us) -> clocks per period, truncated
package strobe_gen_pkg;

  localparam longint unsigned US_PER_S = 64'd1_000_000;

  // Truncating integer division; a result of 0 means the requested period
  // is shorter than one clock, and the instantiating module rejects it.
  function automatic longint unsigned calc_cycles(input longint unsigned clock_hz,
                                                  input longint unsigned period_us);
    return (clock_hz * period_us) / US_PER_S;
  endfunction

endpackage

// File: rtl/strobe_generator_if.sv
// Interface: strobe_generator_if
// Purpose  : Groups the run/strobe signals of the strobe generator so a
//            timer block can hook up to it as a single port.
// Signals  : Enable_i  1  high = run the divider
//            Strobe_o  1  one-clock-wide tick, once per period
// Modports : master  - the consumer (drives Enable_i, receives Strobe_o)
//            slave   - the strobe generator itself
interface strobe_generator_if;

  logic Enable_i;
  logic Strobe_o;

  modport master (
    output Enable_i,
    input  Strobe_o
  );

  modport slave (
    input  Enable_i,
    output Strobe_o
  );

endinterface

// File: rtl/strobe_generator.sv
// Module : strobe_generator
// Purpose: Periodic single-cycle strobe generator. Divides the system clock
//          so that Strobe_o pulses for one clock every PERIOD_US
//          microseconds while enabled. Used as a timebase for timers (e.g.
//          ms tick for tone duration, us tick for tone half-period).
// Params : CLOCK_HZ   system clock frequency in Hz
//          PERIOD_US  strobe period in microseconds
// Ports  : Clock          in   system clock, rising edge
//          Reset          in   asynchronous, active-low reset
//          bus.Enable_i   in   high = run; low = stop (clear or freeze)
//          bus.Strobe_o   out  registered one-clock-wide pulse
// Config : STROBE_GEN_PAUSE_EN
//            undefined - Enable_i low clears the partial count
//            defined   - Enable_i low freezes the count, so re-enabling
//                        resumes the interrupted period
module strobe_generator
  import strobe_gen_pkg::*;
#(
  parameter longint unsigned CLOCK_HZ  = 64'd10_000_000,
  parameter longint unsigned PERIOD_US = 64'd1000
) (
  input  logic                Clock,
  input  logic                Reset,
  strobe_generator_if.slave   bus
);

  localparam longint unsigned CYCLES = calc_cycles(CLOCK_HZ, PERIOD_US);

  // A single-bit counter is still needed when CYCLES == 1; it simply sits
  // at zero and every enabled edge is a terminal count.
  localparam int CW = (CYCLES > 64'd1) ? $clog2(CYCLES) : 1;

  localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES - 64'd1);

  if (CYCLES < 64'd1) begin : g_period_check
    $error("strobe_generator: PERIOD_US is shorter than one clock period");
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          strobe_q;
  logic          strobe_d;

  // Terminal count wraps to zero and fires the strobe in the same edge, so
  // the counter never leaves 0..CYCLES-1 and the strobe repeats every
  // CYCLES enabled edges. A disabled edge never strobes, even at the
  // terminal count.
  always_comb begin
    count_d  = '0;
    strobe_d = 1'b0;
    if (bus.Enable_i) begin
      if (count_q == LAST_COUNT) begin
        count_d  = '0;
        strobe_d = 1'b1;
      end else begin
        count_d  = count_q + CW'(1);
      end
    end else begin
`ifdef STROBE_GEN_PAUSE_EN
      count_d = count_q;
`else
      count_d = '0;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.Strobe_o = strobe_q;

endmodule

// File: tb/tb_strobe_generator.sv
// Testbench: tb_strobe_generator
// Purpose  : Directed, self-checking bench for strobe_generator. Three
//            instances share one clock and reset:
//              dut10   CLOCK_HZ=10e6, PERIOD_US=1     (N = 10)
//              dut10k  CLOCK_HZ=10e6, PERIOD_US=1000  (N = 10000)
//              dut1    CLOCK_HZ=1e6,  PERIOD_US=1     (N = 1)
//            Expected values are hand-derived from N and the cycle index.
//            Inputs change 1 time unit after a rising edge and outputs are
//            sampled at the same point, so each sample reflects the edge
//            just taken.
module tb_strobe_generator;

`ifdef STROBE_GEN_PAUSE_EN
  localparam int RESUME_FIRST = 3;
`else
  localparam int RESUME_FIRST = 10;
`endif

  logic Clock;
  logic Reset;

  int checkCount = 0;
  int passCount  = 0;

  strobe_generator_if if10 ();
  strobe_generator_if if10k ();
  strobe_generator_if if1 ();

  strobe_generator #(
    .CLOCK_HZ (64'd10_000_000),
    .PERIOD_US(64'd1)
  ) dut10 (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (if10)
  );

  strobe_generator #(
    .CLOCK_HZ (64'd10_000_000),
    .PERIOD_US(64'd1000)
  ) dut10k (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (if10k)
  );

  strobe_generator #(
    .CLOCK_HZ (64'd1_000_000),
    .PERIOD_US(64'd1)
  ) dut1 (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (if1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en10, input logic en10k, input logic en1);
    if10.Enable_i  = en10;
    if10k.Enable_i = en10k;
    if1.Enable_i   = en1;
  endtask

  task automatic stepClock();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int p10;
    int p10k;
    int p1;
    int pulseIdx[$];

    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) stepClock();
    checkOutput("reset_strobe10", int'(if10.Strobe_o), 0);
    checkOutput("reset_strobe10k", int'(if10k.Strobe_o), 0);
    checkOutput("reset_strobe1", int'(if1.Strobe_o), 0);
    Reset = 1'b1;

    // Disabled for 1000 clocks: no strobe anywhere
    $display("[TB] disabled idle for 1000 clocks");
    p10 = 0; p10k = 0; p1 = 0;
    for (int k = 1; k <= 1000; k++) begin
      stepClock();
      p10  += int'(if10.Strobe_o);
      p10k += int'(if10k.Strobe_o);
      p1   += int'(if1.Strobe_o);
    end
    checkOutput("idle_pulses10", p10, 0);
    checkOutput("idle_pulses10k", p10k, 0);
    checkOutput("idle_pulses1", p1, 0);

    // N=10, enable held: pulse after every 10th enabled edge
    $display("[TB] N=10 continuous enable");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      stepClock();
      checkOutput($sformatf("n10_run_edge%0d", k), int'(if10.Strobe_o), (k % 10 == 0) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("n10_disable", int'(if10.Strobe_o), 0);

    // Async reset mid-count (N=10 at count 5, N=1 strobing)
    $display("[TB] async reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      stepClock();
      checkOutput($sformatf("pre_reset10_edge%0d", k), int'(if10.Strobe_o), 0);
      checkOutput($sformatf("pre_reset1_edge%0d", k), int'(if1.Strobe_o), 1);
    end
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("async_reset_strobe1", int'(if1.Strobe_o), 0);
    checkOutput("async_reset_strobe10", int'(if10.Strobe_o), 0);
    stepClock();
    checkOutput("held_reset_strobe1", int'(if1.Strobe_o), 0);
    Reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepClock();
      checkOutput($sformatf("post_reset10_edge%0d", k), int'(if10.Strobe_o), (k == 10) ? 1 : 0);
      checkOutput($sformatf("n1_edge%0d", k), int'(if1.Strobe_o), 1);
    end

    // N=1: disable drops the strobe on the next edge
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("n1_disable", int'(if1.Strobe_o), 0);
    stepClock();
    checkOutput("n1_disable_hold", int'(if1.Strobe_o), 0);

    // Clean start for the pause/resume scenario
    Reset = 1'b0;
    #3;
    Reset = 1'b1;

    // N=10: 7 enabled, 3 disabled, then re-enable
    $display("[TB] N=10 enable 7 / disable 3 / re-enable");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      stepClock();
      checkOutput($sformatf("partial_edge%0d", k), int'(if10.Strobe_o), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      stepClock();
      checkOutput($sformatf("paused_edge%0d", k), int'(if10.Strobe_o), 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      stepClock();
      checkOutput($sformatf("resume_edge%0d", k), int'(if10.Strobe_o), (k == RESUME_FIRST) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    #3;
    Reset = 1'b1;

    // N=10000 for 35000 clocks: exactly 3 pulses, 10000 apart
    $display("[TB] N=10000 long run");
    applyStimulus(1'b0, 1'b1, 1'b0);
    p10k = 0;
    for (int k = 1; k <= 35000; k++) begin
      stepClock();
      if (if10k.Strobe_o === 1'b1) begin
        p10k++;
        pulseIdx.push_back(k);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("long_pulse_count", p10k, 3);
    if (pulseIdx.size() >= 3) begin
      checkOutput("long_first_pulse", pulseIdx[0], 10000);
      checkOutput("long_spacing_1_2", pulseIdx[1] - pulseIdx[0], 10000);
      checkOutput("long_spacing_2_3", pulseIdx[2] - pulseIdx[1], 10000);
    end else begin
      checkOutput("long_pulse_positions", pulseIdx.size(), 3);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
